// File: rtl/pm_pkg.sv
// pm_pkg: shared sizes and types for the program-memory page loader.
// Page/offset widths, word width and the fill FSM state encoding.
package pm_pkg;

  localparam int PAGE_BITS   = 3;
  localparam int OFFSET_BITS = 5;
  localparam int DATA_W      = 8;
  localparam int ADDR_W      = PAGE_BITS + OFFSET_BITS;
  localparam int DEPTH       = 2 ** OFFSET_BITS;

  typedef logic [PAGE_BITS-1:0]   page_t;
  typedef logic [OFFSET_BITS-1:0] offset_t;

  typedef enum logic {
    S_READY,
    S_FILL
  } pm_fill_state_t;

endpackage

// File: rtl/pm_page_buf.sv
// pm_page_buf: one page of program memory, DEPTH x DATA_W registers.
// Ports: clk; we/waddr/wdata sync write; raddr -> rdata one cycle later.
module pm_page_buf
  import pm_pkg::*;
(
  input  logic                   clk,
  input  logic                   we,
  input  logic [OFFSET_BITS-1:0] waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [OFFSET_BITS-1:0] raddr,
  output logic [DATA_W-1:0]      rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pm_page_loader.sv
// pm_page_loader: caches one program page; fills it from slow ROM on a miss.
// Ports: clk, sync_reset; pm_addr in, instr/instr_valid out; stall to the
// sequencer; mem_rd_req/mem_addr/mem_rd_valid/mem_rd_data to the ROM;
// miss_count = saturating count of page fills started.
module pm_page_loader
  import pm_pkg::*;
(
  input  logic              clk,
  input  logic              sync_reset,
  input  logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              stall,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [15:0]       miss_count
);

  pm_fill_state_t state, state_nxt;

  logic              page_valid;
  logic              outstanding;
  logic              hit_q;
  page_t             cur_page;
  page_t             fill_page;
  page_t             addr_page;
  offset_t           fill_cnt;
  offset_t           addr_off;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] rdata;
  logic [15:0]       miss_q;
  logic              miss;
  logic              take;
  logic              last;

  assign addr_page = pm_addr[ADDR_W-1:OFFSET_BITS];
  assign addr_off  = pm_addr[OFFSET_BITS-1:0];
  assign miss      = ~page_valid | (addr_page != cur_page);

  // A return only counts while our own request is in flight.
  assign take = mem_rd_valid & outstanding;
  assign last = take & (fill_cnt == '1);

  always_ff @(posedge clk) begin
    if (sync_reset) state <= S_READY;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_READY: if (miss) state_nxt = S_FILL;
      S_FILL:  if (last) state_nxt = S_READY;
    endcase
  end

  always_comb begin
    stall      = (state == S_FILL) | miss;
    mem_rd_req = (state == S_FILL) & ~outstanding & ~sync_reset;
    mem_addr   = {fill_page, fill_cnt};
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      page_valid  <= 1'b0;
      cur_page    <= '0;
      fill_page   <= '0;
      fill_cnt    <= '0;
      outstanding <= 1'b0;
      hit_q       <= 1'b0;
      instr_q     <= '0;
      miss_q      <= '0;
    end else begin
      hit_q <= (state == S_READY) & ~miss;
      if (hit_q) instr_q <= rdata;
      if (state == S_READY && miss) begin
        fill_page  <= addr_page;
        fill_cnt   <= '0;
        page_valid <= 1'b0;
        if (miss_q != '1) miss_q <= miss_q + 16'd1;
      end
      if (mem_rd_req) outstanding <= 1'b1;
      if (take) begin
        outstanding <= 1'b0;
        fill_cnt    <= fill_cnt + offset_t'(1);
      end
      if (last) begin
        cur_page   <= fill_page;
        page_valid <= 1'b1;
      end
    end
  end

  pm_page_buf u_buf (
    .clk   (clk),
    .we    (take & ~sync_reset),
    .waddr (fill_cnt),
    .wdata (mem_rd_data),
    .raddr (addr_off),
    .rdata (rdata)
  );

  // The read register holds the word only for the cycle after a hit;
  // instr_q keeps it visible through later misses and fills.
  assign instr       = hit_q ? rdata : instr_q;
  assign instr_valid = hit_q;
  assign miss_count  = miss_q;

endmodule

// File: tb/tb_pm_page_loader.sv
// tb_pm_page_loader: self-checking bench for pm_page_loader.
// Models the ROM (fixed or random latency) and the page cache behaviour.
module tb_pm_page_loader;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic [7:0]  pm_addr;
  logic [7:0]  instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_rd_req;
  logic [7:0]  mem_addr;
  logic        mem_rd_valid;
  logic [7:0]  mem_rd_data;
  logic [15:0] miss_count;

  int n_cmp = 0;
  int n_bad = 0;

  int         rom_cnt  = 0;
  int         lat_sum  = 0;
  int         fix_lat  = 1;
  bit         rand_lat = 1'b0;
  logic [7:0] rom_addr = 8'h00;
  logic [7:0] req_q[$];

  typedef struct {
    logic [7:0] addr;
    logic       exp_stall;
    logic       exp_valid;
    logic [7:0] exp_instr;
  } vec_t;

  vec_t vecs[31];

  always #5 clk = ~clk;

  pm_page_loader dut (
    .clk          (clk),
    .sync_reset   (sync_reset),
    .pm_addr      (pm_addr),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .mem_rd_req   (mem_rd_req),
    .mem_addr     (mem_addr),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .miss_count   (miss_count)
  );

  function automatic logic [7:0] rom(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input logic [7:0] a, output int n);
    pm_addr = a;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 3000) begin
      n++;
      cyc();
    end
    if (n >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fill_timeout: stall high %0d cycles, required low", n);
    end
  endtask

  task automatic check_reqs(input logic [7:0] base);
    int bad = 0;
    check("fill_req_count", 32'(req_q.size()), 32);
    foreach (req_q[i]) if (req_q[i] !== base + 8'(i)) bad++;
    check("fill_req_addrs", 32'(bad), 0);
  endtask

  // Backing ROM: one response per request after the chosen latency.
  initial begin
    mem_rd_valid = 1'b0;
    mem_rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      mem_rd_valid = 1'b0;
      if (rom_cnt > 0) begin
        rom_cnt--;
        if (rom_cnt == 0) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = rom(rom_addr);
        end
      end
      if (mem_rd_req === 1'b1) begin
        check("one_in_flight",
              32'((rom_cnt != 0) || mem_rd_valid), 0);
        req_q.push_back(mem_addr);
        rom_addr = mem_addr;
        rom_cnt  = rand_lat ? int'($urandom_range(5, 1)) : fix_lat;
        lat_sum += rom_cnt;
      end
    end
  end

  initial begin
    int n;
    int w;
    logic [2:0] mpage;
    logic [2:0] pg;
    logic [7:0] a;
    logic [7:0] prev;

    for (int i = 0; i < 31; i++) begin
      vecs[i].addr      = 8'(i + 1);
      vecs[i].exp_stall = 1'b0;
      vecs[i].exp_valid = 1'b1;
      vecs[i].exp_instr = rom(8'(i));
    end

    sync_reset = 1'b1;
    pm_addr    = 8'h00;
    repeat (3) cyc();
    check("rst_instr", 32'(instr), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_req", 32'(mem_rd_req), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_miss_count", 32'(miss_count), 0);

    // Cold start, ROM latency 1.
    sync_reset = 1'b0;
    req_q.delete();
    do_fill(8'h00, n);
    check("cold_fill_cycles", 32'(n), 65);
    check_reqs(8'h00);
    check("cold_miss_count", 32'(miss_count), 1);
    req_q.delete();

    // Sequential hits through the page.
    foreach (vecs[i]) begin
      cyc();
      pm_addr = vecs[i].addr;
      #1;
      check("seq_stall", 32'(stall), 32'(vecs[i].exp_stall));
      check("seq_valid", 32'(instr_valid), 32'(vecs[i].exp_valid));
      check("seq_instr", 32'(instr), 32'(vecs[i].exp_instr));
    end
    check("seq_no_req", 32'(req_q.size()), 0);

    // Page change 1F -> 20.
    cyc();
    pm_addr = 8'h20;
    #1;
    check("pg_stall_now", 32'(stall), 1);
    do_fill(8'h20, n);
    check("pg_fill_cycles", 32'(n), 65);
    check_reqs(8'h20);
    cyc();
    check("pg_valid", 32'(instr_valid), 1);
    check("pg_instr", 32'(instr), 32'h85);
    check("pg_miss_count", 32'(miss_count), 2);
    mpage = 3'd1;

    // Random pages and offsets, random ROM latency.
    rand_lat = 1'b1;
    for (int r = 0; r < 6; r++) begin
      pg = 3'($urandom_range(7, 0));
      a  = {pg, 5'($urandom_range(31, 0))};
      cyc();
      req_q.delete();
      lat_sum = 0;
      pm_addr = a;
      #1;
      check("rnd_stall", 32'(stall), 32'(pg != mpage));
      if (pg != mpage) begin
        do_fill(a, n);
        check("rnd_fill_cycles", 32'(n), 32'(33 + lat_sum));
        check_reqs({pg, 5'd0});
        mpage = pg;
      end
      prev = a;
      for (int k = 0; k < 16; k++) begin
        cyc();
        a = {pg, 5'($urandom_range(31, 0))};
        pm_addr = a;
        #1;
        check("rnd_hit_stall", 32'(stall), 0);
        check("rnd_valid", 32'(instr_valid), 1);
        check("rnd_instr", 32'(instr), 32'(rom(prev)));
        prev = a;
      end
    end

    // Reset after the 10th return, with the 11th request in flight.
    rand_lat = 1'b0;
    fix_lat  = 3;
    cyc();
    req_q.delete();
    pm_addr = {mpage + 3'd1, 5'd0};
    w = 0;
    while (req_q.size() < 11 && w < 2000) begin
      cyc();
      w++;
    end
    check("rst_mid_wait", 32'(w < 2000), 1);
    sync_reset = 1'b1;
    cyc();
    cyc();
    sync_reset = 1'b0;
    check("rst_mid_miss_count", 32'(miss_count), 0);
    check("rst_mid_valid", 32'(instr_valid), 0);
    req_q.delete();
    do_fill(8'h00, n);
    check("refill_cycles", 32'(n), 129);
    check_reqs(8'h00);
    check("refill_miss_count", 32'(miss_count), 1);
    cyc();
    check("refill_instr", 32'(instr), 32'hA5);

    // Saturation of miss_count.
    fix_lat = 1;
    force dut.miss_q = 16'hFFFE;
    #1;
    release dut.miss_q;
    for (int j = 1; j <= 3; j++) begin
      cyc();
      do_fill({3'(j), 5'd0}, n);
      check("sat_miss_count", 32'(miss_count), 32'hFFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
